mem_dist_stream_reader: RTL and testbench

//  Downstream consumer of the distributed-memory buffer (mem_dist read port B). On a start command,

---
 rtl/mem_dist_stream_reader.sv | 218 +++++++++++++++++++++
 tb/tb_mem_dist_stream_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dist_stream_reader.sv
// mem_dist_stream_reader
//   Reads a run of consecutive words from read port B of the distributed-memory
//   buffer and presents them as an AXI-Stream. The memory's one-cycle registered
//   read latency and downstream backpressure are absorbed by a two-entry skid
//   FIFO. The reader sustains one beat per cycle while m_axis_tready is high.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   start           command pulse, accepted only while busy=0
//   base_addr, len  first address / word count, sampled when start is accepted
//   stride          (STRIDE_EN builds only) address step, sampled at start
//   busy, done      transfer in progress / one-cycle completion pulse
//   mem_en,mem_addr read request to the memory (enB / addrB)
//   mem_dout        memory read data (doutB), valid the cycle after mem_en
//   m_axis_*        AXI-Stream master (tdata/tvalid/tready/tlast)
//
// Build option
//   STRIDE_EN  when defined, adds the stride port and the address advances by
//              stride (mod DEPTH) per read; otherwise the step is fixed at 1.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | issuing reads, one per cycle while the FIFO has room
// S_DRAIN | all reads issued; emptying the FIFO until the tlast beat
// S_ZERO  | zero-length command; done pulse, no beats

module mem_dist_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] len,
`ifdef STRIDE_EN
    input  logic [AW-1:0]    stride,
`endif
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_ZERO  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] fifo_data_q [2];
    logic [WIDTH-1:0] fifo_data_d [2];
    logic [1:0]       fifo_last_q, fifo_last_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    logic             push;
    logic             pop;
    logic             issue;
    logic [2:0]       pending;
    logic [AW-1:0]    step;
    logic [AW:0]      addr_sum;
    logic [AW-1:0]    addr_next;

`ifdef STRIDE_EN
    logic [AW-1:0]    stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    // FIFO head drives the stream; data and last are forced low when empty so
    // the idle/reset output state is all zeros.
    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[rd_ptr_q];

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = inflight_q;

    // A read may be issued only if its word is guaranteed a FIFO slot when it
    // returns next cycle: entries held plus the read already in flight must
    // stay within two, counting a pop happening this cycle.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
    assign issue   = (state_q == S_RUN) &&
                     ((pending < 3'd2) || ((pending == 3'd2) && pop));

    // Modulo-DEPTH advance that also holds for non-power-of-two depths.
    assign addr_sum  = {1'b0, addr_q} + {1'b0, step};
    assign addr_next = (addr_sum >= (AW+1)'(DEPTH)) ? AW'(addr_sum - (AW+1)'(DEPTH))
                                                    : addr_sum[AW-1:0];

    assign mem_en   = issue;
    assign mem_addr = addr_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = done_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == LEN_W'(1));
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q + {1'b0, push} - {1'b0, pop};
`ifdef STRIDE_EN
        stride_d        = stride_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = len;
`ifdef STRIDE_EN
                    stride_d = stride;
`endif
                    if (len == '0) begin
                        state_d = S_ZERO;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_next;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_dout;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= '0;
`ifdef STRIDE_EN
            stride_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
`ifdef STRIDE_EN
            stride_q        <= stride_d;
`endif
        end
    end

    // The issue rule must make a push into a full FIFO without a pop impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_mem_dist_stream_reader.sv
module tb_mem_dist_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LEN_W = 10;

    logic             clk;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    stride;
    logic             busy;
    logic             done;
    logic             mem_en;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_dout = '0;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    mem_dist_stream_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .len           (len),
`ifdef STRIDE_EN
        .stride        (stride),
`endif
        .busy          (busy),
        .done          (done),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read port B: registered read, output held while not enabled.
    logic [WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: logs issued read addresses and accepted beats, and checks that
    // a stalled beat is held unchanged into the next cycle.
    logic [AW-1:0]    addr_log [$];
    logic [WIDTH:0]   beat_q [$];
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
                chk("hold_data", 64'(m_axis_tdata), 64'(prev_data));
                chk("hold_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (mem_en) addr_log.push_back(mem_addr);
            if (m_axis_tvalid && m_axis_tready) beat_q.push_back({m_axis_tlast, m_axis_tdata});
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Runs one command from a cycle boundary until a few cycles past done.
    // dup_at > 0 pulses a second (to-be-ignored) start in that cycle.
    task automatic run_xfer(input int b, input int n, input bit stall, input int dup_at,
                            output int dones);
        int cyc;
        int after;
        beat_q.delete();
        addr_log.delete();
        dones         = 0;
        start         = 1'b1;
        base_addr     = AW'(b);
        len           = LEN_W'(n);
        m_axis_tready = stall ? rdy_pat[0] : 1'b1;
        cyc   = 0;
        after = 0;
        while (cyc < 300 && after < 3) begin
            tick();
            cyc++;
            start = (cyc == dup_at);
            if (cyc == dup_at) begin
                base_addr = AW'(256);
                len       = LEN_W'(2);
            end
            m_axis_tready = stall ? rdy_pat[cyc % 4] : 1'b1;
            if (done) dones++;
            if (dones != 0) after++;
        end
        start         = 1'b0;
        m_axis_tready = 1'b1;
        chk("xfer_completes", 64'(dones != 0), 64'(1));
    endtask

    task automatic check_stream(input string tag, input int b, input int n, input int step);
        int a;
        chk({tag, "_beats"}, 64'(beat_q.size()), 64'(n));
        chk({tag, "_reads"}, 64'(addr_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = (b + i * step) % DEPTH;
            if (i < addr_log.size()) chk({tag, "_addr"}, 64'(addr_log[i]), 64'(a));
            if (i < beat_q.size())
                chk({tag, "_beat"}, 64'(beat_q[i]), 64'({i == n - 1, WIDTH'(a)}));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'(0));
        chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int dones;
    int exp3 [4] = '{510, 511, 0, 1};
    int exp6 [4] = '{3, 19, 35, 51};

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        len           = '0;
        stride        = AW'(1);
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: base 0x010, len 4, tready high, cycle-exact
        start = 1'b1; base_addr = AW'(16); len = LEN_W'(4); m_axis_tready = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_c1_busy", 64'(busy), 64'(1));
        chk("t1_c1_en", 64'(mem_en), 64'(1));
        chk("t1_c1_addr", 64'(mem_addr), 64'(16));
        chk("t1_c1_tvalid", 64'(m_axis_tvalid), 64'(0));
        tick();
        chk("t1_c2_en", 64'(mem_en), 64'(1));
        chk("t1_c2_addr", 64'(mem_addr), 64'(17));
        chk("t1_c2_tvalid", 64'(m_axis_tvalid), 64'(0));
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk("t1_tvalid", 64'(m_axis_tvalid), 64'(1));
            chk("t1_tdata", 64'(m_axis_tdata), 64'(16 + c - 3));
            chk("t1_tlast", 64'(m_axis_tlast), 64'(c == 6));
            chk("t1_done_early", 64'(done), 64'(0));
        end
        tick();
        chk("t1_c7_done", 64'(done), 64'(1));
        chk("t1_c7_busy", 64'(busy), 64'(0));
        chk("t1_c7_tvalid", 64'(m_axis_tvalid), 64'(0));
        tick();
        chk("t1_c8_done", 64'(done), 64'(0));

        // 2: len 8 under backpressure 1,0,0,1,...
        run_xfer(64, 8, 1'b1, -1, dones);
        chk("t2_dones", 64'(dones), 64'(1));
        check_stream("t2", 64, 8, 1);

        // 3: wrap at the top of memory
        run_xfer(DEPTH - 2, 4, 1'b0, -1, dones);
        chk("t3_dones", 64'(dones), 64'(1));
        check_stream("t3", DEPTH - 2, 4, 1);
        for (int i = 0; i < 4; i++)
            if (i < addr_log.size()) chk("t3_wrap_addr", 64'(addr_log[i]), 64'(exp3[i]));

        // 4: zero length
        beat_q.delete();
        addr_log.delete();
        start = 1'b1; base_addr = AW'(51); len = '0;
        tick();
        start = 1'b0;
        chk("t4_done", 64'(done), 64'(1));
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_en", 64'(mem_en), 64'(0));
        chk("t4_tvalid", 64'(m_axis_tvalid), 64'(0));
        tick();
        chk("t4_done_clr", 64'(done), 64'(0));
        repeat (3) tick();
        chk("t4_no_beats", 64'(beat_q.size()), 64'(0));
        chk("t4_no_reads", 64'(addr_log.size()), 64'(0));

        // 5: reset mid-transfer with tready low, then a clean transfer
        m_axis_tready = 1'b0;
        start = 1'b1; base_addr = AW'(0); len = LEN_W'(16);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_pre_tvalid", 64'(m_axis_tvalid), 64'(1));
        rst = 1'b1;
        tick();
        check_idle_outputs("t5_rst");
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        run_xfer(32, 4, 1'b0, -1, dones);
        chk("t5_dones", 64'(dones), 64'(1));
        check_stream("t5", 32, 4, 1);

        // start while busy is ignored
        run_xfer(128, 4, 1'b0, 2, dones);
        chk("busy_start_dones", 64'(dones), 64'(1));
        check_stream("busy_start", 128, 4, 1);

`ifdef STRIDE_EN
        // 6: strided read
        stride = AW'(16);
        run_xfer(3, 4, 1'b0, 2, dones);
        stride = AW'(1);
        chk("t6_dones", 64'(dones), 64'(1));
        check_stream("t6", 3, 4, 16);
        for (int i = 0; i < 4; i++)
            if (i < addr_log.size()) chk("t6_stride_addr", 64'(addr_log[i]), 64'(exp6[i]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
